// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD-to-ASCII sender:
//   - FSM state type and state encodings
//   - ASCII character constants used on the transmit path
//   - packed container for the three latched BCD digits
//   - helper that tells whether a state offers a character
// ---------------------------------------------------------------------------
package bcd_pkg;

  // FSM state type. The encodings are plain constants so that older tools
  // and waveform viewers show stable numeric values.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_D2   = 3'd1;
  localparam state_t ST_D1   = 3'd2;
  localparam state_t ST_D0   = 3'd3;
  localparam state_t ST_CR   = 3'd4;
  localparam state_t ST_LF   = 3'd5;
  localparam state_t ST_FIN  = 3'd6;

  // ASCII characters produced by the sender.
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // Hundreds / tens / units, most significant first.
  typedef struct packed {
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } bcd_digits_t;

  // True for every state in which a character is offered to the transmitter.
  function automatic logic is_char_state(input state_t s);
    return (s == ST_D2) || (s == ST_D1) || (s == ST_D0) ||
           (s == ST_CR) || (s == ST_LF);
  endfunction

endpackage : bcd_pkg

// File: rtl/bcd_to_ascii.sv
// ---------------------------------------------------------------------------
// bcd_to_ascii
// Combinational mapping of one BCD digit to its ASCII character.
// Values 0..9 map to '0'..'9'; the non-BCD codes 10..15 map to '?'.
//
// Ports
//   i_digit  in   4  BCD digit
//   o_char   out  8  ASCII character
// ---------------------------------------------------------------------------
module bcd_to_ascii
  import bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [7:0] o_char
);

  assign o_char = (i_digit <= 4'd9) ? (ASCII_ZERO + {4'h0, i_digit})
                                    : ASCII_QMARK;

endmodule : bcd_to_ascii

// File: rtl/bcd_ascii_sender.sv
// ---------------------------------------------------------------------------
// bcd_ascii_sender
// Sends a three-digit BCD value as ASCII characters over a valid/ready byte
// interface, optionally suppressing leading zeros and optionally terminating
// the line with CR LF. A one-cycle done pulse marks the end of each send.
//
// Parameters
//   BLANK_ZEROS  1: skip leading zero hundreds/tens (units always sent)
//   SEND_CRLF    1: append CR then LF after the units digit
//
// Ports
//   clk       in   1  clock, all state changes on the rising edge
//   rst_n     in   1  asynchronous active-low reset
//   start     in   1  request to send the digits (accepted only when idle)
//   digit2    in   4  BCD hundreds
//   digit1    in   4  BCD tens
//   digit0    in   4  BCD units
//   tx_data   out  8  character offered to the transmitter (registered)
//   tx_valid  out  1  tx_data is valid (decoded from state)
//   tx_ready  in   1  transmitter accepts tx_data this cycle
//   busy      out  1  send in progress (decoded from state)
//   done      out  1  one-cycle pulse after the last character (registered)
// ---------------------------------------------------------------------------
module bcd_ascii_sender
  import bcd_pkg::*;
#(
  parameter bit BLANK_ZEROS = 1'b1,
  parameter bit SEND_CRLF   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] digit2,
  input  logic [3:0] digit1,
  input  logic [3:0] digit0,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
);

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  state_t      r_state;
  bcd_digits_t r_digits;
  logic [7:0]  r_tx_data;
  logic        r_done;

  state_t      w_next_state;
  bcd_digits_t w_digits_src;
  logic        w_accept;
  logic        w_xfer;
  logic        w_char_state;
  logic [3:0]  w_sel_digit;
  logic [7:0]  w_digit_char;
  logic [7:0]  w_next_char;

  assign w_char_state = is_char_state(r_state);
  assign w_accept     = (r_state == ST_IDLE) && start;
  assign w_xfer       = w_char_state && tx_ready;

  // On the accepting edge the new digits are not yet in r_digits, so the
  // first character is built straight from the inputs being latched.
  assign w_digits_src = w_accept ? {digit2, digit1, digit0} : r_digits;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so that
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (!BLANK_ZEROS || (digit2 != 4'd0)) begin
            w_next_state = ST_D2;
          end else if (digit1 != 4'd0) begin
            w_next_state = ST_D1;
          end else begin
            w_next_state = ST_D0;
          end
        end
      end
      ST_D2:   if (w_xfer) w_next_state = ST_D1;
      ST_D1:   if (w_xfer) w_next_state = ST_D0;
      ST_D0:   if (w_xfer) w_next_state = SEND_CRLF ? ST_CR : ST_FIN;
      ST_CR:   if (w_xfer) w_next_state = ST_LF;
      ST_LF:   if (w_xfer) w_next_state = ST_FIN;
      ST_FIN:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Character generation
  // tx_data is registered, so the character is chosen for the state being
  // entered. While stalled the next state equals the current one and the
  // digits are frozen, which keeps tx_data stable.
  // -------------------------------------------------------------------------
  always_comb begin
    w_sel_digit = 4'd0;
    case (w_next_state)
      ST_D2:   w_sel_digit = w_digits_src.d2;
      ST_D1:   w_sel_digit = w_digits_src.d1;
      ST_D0:   w_sel_digit = w_digits_src.d0;
      default: w_sel_digit = 4'd0;
    endcase
  end

  bcd_to_ascii u_bcd_to_ascii (
    .i_digit (w_sel_digit),
    .o_char  (w_digit_char)
  );

  always_comb begin
    w_next_char = 8'h00;
    case (w_next_state)
      ST_D2, ST_D1, ST_D0: w_next_char = w_digit_char;
      ST_CR:               w_next_char = ASCII_CR;
      ST_LF:               w_next_char = ASCII_LF;
      default:             w_next_char = 8'h00;
    endcase
  end

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      // NOTE: the digit register is reset too: a reset mid-send must leave
      // no stale value behind that could leak into a later character.
      r_digits  <= '0;
      r_tx_data <= 8'h00;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      if (w_accept) begin
        r_digits <= w_digits_src;
      end
      r_tx_data <= w_next_char;
      r_done    <= (w_next_state == ST_FIN);
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign tx_data  = r_tx_data;
  assign done     = r_done;
  assign tx_valid = w_char_state;
  assign busy     = w_char_state;

endmodule : bcd_ascii_sender

// File: tb/tb_bcd_ascii_sender.sv
// ---------------------------------------------------------------------------
// tb_bcd_ascii_sender
// Directed bench for bcd_ascii_sender. Two instances share all inputs:
//   u_main  default parameters (blanking on, CR LF on)
//   u_raw   BLANK_ZEROS=0, SEND_CRLF=0
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bcd_ascii_sender;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       tx_ready = 1'b0;
  logic [3:0] d2 = 4'd0;
  logic [3:0] d1 = 4'd0;
  logic [3:0] d0 = 4'd0;

  logic [7:0] m_data, r_data;
  logic       m_valid, m_busy, m_done;
  logic       r_valid, r_busy, r_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_ascii_sender u_main (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .digit2   (d2),
    .digit1   (d1),
    .digit0   (d0),
    .tx_data  (m_data),
    .tx_valid (m_valid),
    .tx_ready (tx_ready),
    .busy     (m_busy),
    .done     (m_done)
  );

  bcd_ascii_sender #(
    .BLANK_ZEROS (1'b0),
    .SEND_CRLF   (1'b0)
  ) u_raw (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .digit2   (d2),
    .digit1   (d1),
    .digit0   (d0),
    .tx_data  (r_data),
    .tx_valid (r_valid),
    .tx_ready (tx_ready),
    .busy     (r_busy),
    .done     (r_done)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle with the given digits, then scramble the digit
  // inputs so any use of unlatched inputs shows up as a wrong character.
  task automatic start_send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    d2 = a; d1 = b; d0 = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; d2 = 4'hE; d1 = 4'hE; d0 = 4'hE;
  endtask

  // Expect one character held for 'stalls' cycles with tx_ready low, then
  // transferred with tx_ready high.
  task automatic expect_char(input string tag, input bit raw, input logic [7:0] exp,
                             input int stalls);
    for (int s = 0; s < stalls; s++) begin
      tx_ready = 1'b0;
      check({tag, "_stall_valid"}, raw ? {7'd0, r_valid} : {7'd0, m_valid}, 8'h01);
      check({tag, "_stall_data"},  raw ? r_data : m_data, exp);
      @(negedge clk);
    end
    tx_ready = 1'b1;
    check({tag, "_valid"}, raw ? {7'd0, r_valid} : {7'd0, m_valid}, 8'h01);
    check({tag, "_data"},  raw ? r_data : m_data, exp);
    check({tag, "_busy"},  raw ? {7'd0, r_busy} : {7'd0, m_busy}, 8'h01);
    @(negedge clk);
  endtask

  // Expect the single FIN cycle, then an idle cycle.
  task automatic expect_fin(input string tag, input bit raw);
    check({tag, "_fin_done"},  raw ? {7'd0, r_done}  : {7'd0, m_done},  8'h01);
    check({tag, "_fin_valid"}, raw ? {7'd0, r_valid} : {7'd0, m_valid}, 8'h00);
    check({tag, "_fin_busy"},  raw ? {7'd0, r_busy}  : {7'd0, m_busy},  8'h00);
    @(negedge clk);
    check({tag, "_idle_done"},  raw ? {7'd0, r_done}  : {7'd0, m_done},  8'h00);
    check({tag, "_idle_valid"}, raw ? {7'd0, r_valid} : {7'd0, m_valid}, 8'h00);
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_valid", {7'd0, m_valid}, 8'h00);
    check("rst_busy",  {7'd0, m_busy},  8'h00);
    check("rst_done",  {7'd0, m_done},  8'h00);
    check("rst_data",  m_data,          8'h00);
    check("rst_raw_valid", {7'd0, r_valid}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    tx_ready = 1'b1;
    @(negedge clk);
    check("post_rst_valid", {7'd0, m_valid}, 8'h00);

    // 1,2,3 with full line ending, one character per cycle
    start_send(4'd1, 4'd2, 4'd3);
    expect_char("v123_c0", 1'b0, 8'h31, 0);
    expect_char("v123_c1", 1'b0, 8'h32, 0);
    expect_char("v123_c2", 1'b0, 8'h33, 0);
    expect_char("v123_cr", 1'b0, 8'h0D, 0);
    expect_char("v123_lf", 1'b0, 8'h0A, 0);
    expect_fin("v123", 1'b0);

    // Leading-zero blanking
    start_send(4'd0, 4'd0, 4'd7);
    expect_char("v007_c0", 1'b0, 8'h37, 0);
    expect_char("v007_cr", 1'b0, 8'h0D, 0);
    expect_char("v007_lf", 1'b0, 8'h0A, 0);
    expect_fin("v007", 1'b0);

    start_send(4'd0, 4'd0, 4'd0);
    expect_char("v000_c0", 1'b0, 8'h30, 0);
    expect_char("v000_cr", 1'b0, 8'h0D, 0);
    expect_char("v000_lf", 1'b0, 8'h0A, 0);
    expect_fin("v000", 1'b0);

    start_send(4'd0, 4'd5, 4'd0);
    expect_char("v050_c0", 1'b0, 8'h35, 0);
    expect_char("v050_c1", 1'b0, 8'h30, 0);
    expect_char("v050_cr", 1'b0, 8'h0D, 0);
    expect_char("v050_lf", 1'b0, 8'h0A, 0);
    expect_fin("v050", 1'b0);

    // Non-BCD hundreds is not blank and shows as '?'
    start_send(4'hB, 4'd0, 4'd0);
    expect_char("vB00_c0", 1'b0, 8'h3F, 0);
    expect_char("vB00_c1", 1'b0, 8'h30, 0);
    expect_char("vB00_c2", 1'b0, 8'h30, 0);
    expect_char("vB00_cr", 1'b0, 8'h0D, 0);
    expect_char("vB00_lf", 1'b0, 8'h0A, 0);
    expect_fin("vB00", 1'b0);

    // Back-pressure: 3 stall cycles on each character, 20 cycles in total
    start_send(4'd4, 4'd5, 4'd6);
    expect_char("v456s_c0", 1'b0, 8'h34, 3);
    expect_char("v456s_c1", 1'b0, 8'h35, 3);
    expect_char("v456s_c2", 1'b0, 8'h36, 3);
    expect_char("v456s_cr", 1'b0, 8'h0D, 3);
    expect_char("v456s_lf", 1'b0, 8'h0A, 3);
    expect_fin("v456s", 1'b0);

    // start mid-send and in FIN ignored; start in the following IDLE accepted
    start_send(4'd1, 4'd2, 4'd3);
    expect_char("busy_c0", 1'b0, 8'h31, 0);
    expect_char("busy_c1", 1'b0, 8'h32, 0);
    d2 = 4'd9; d1 = 4'd9; d0 = 4'd9; start = 1'b1;
    expect_char("busy_c2", 1'b0, 8'h33, 0);
    start = 1'b0;
    expect_char("busy_cr", 1'b0, 8'h0D, 0);
    expect_char("busy_lf", 1'b0, 8'h0A, 0);
    d2 = 4'd7; d1 = 4'd8; d0 = 4'd9; start = 1'b1;
    expect_fin("busy", 1'b0);
    start_send(4'd2, 4'd0, 4'd0);
    expect_char("v200_c0", 1'b0, 8'h32, 0);
    expect_char("v200_c1", 1'b0, 8'h30, 0);
    expect_char("v200_c2", 1'b0, 8'h30, 0);
    expect_char("v200_cr", 1'b0, 8'h0D, 0);
    expect_char("v200_lf", 1'b0, 8'h0A, 0);
    expect_fin("v200", 1'b0);

    // No blanking, no CR LF
    start_send(4'hA, 4'd0, 4'd1);
    expect_char("rawA01_c0", 1'b1, 8'h3F, 0);
    expect_char("rawA01_c1", 1'b1, 8'h30, 0);
    expect_char("rawA01_c2", 1'b1, 8'h31, 0);
    expect_fin("rawA01", 1'b1);
    repeat (3) @(negedge clk);

    start_send(4'd0, 4'd0, 4'd5);
    expect_char("raw005_c0", 1'b1, 8'h30, 0);
    expect_char("raw005_c1", 1'b1, 8'h30, 0);
    expect_char("raw005_c2", 1'b1, 8'h35, 0);
    expect_fin("raw005", 1'b1);
    repeat (3) @(negedge clk);

    // Asynchronous reset after two transferred bytes
    start_send(4'd4, 4'd5, 4'd6);
    expect_char("rstmid_c0", 1'b0, 8'h34, 0);
    expect_char("rstmid_c1", 1'b0, 8'h35, 0);
    rst_n = 1'b0;
    #1;
    check("rstmid_valid", {7'd0, m_valid}, 8'h00);
    check("rstmid_busy",  {7'd0, m_busy},  8'h00);
    check("rstmid_done",  {7'd0, m_done},  8'h00);
    check("rstmid_data",  m_data,          8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstmid_quiet_valid", {7'd0, m_valid}, 8'h00);
      check("rstmid_quiet_busy",  {7'd0, m_busy},  8'h00);
    end
    start_send(4'd0, 4'd0, 4'd1);
    expect_char("v001_c0", 1'b0, 8'h31, 0);
    expect_char("v001_cr", 1'b0, 8'h0D, 0);
    expect_char("v001_lf", 1'b0, 8'h0A, 0);
    expect_fin("v001", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bcd_ascii_sender

// File: doc/bcd_ascii_sender.md
BCD_ASCII_SENDER -- requirements
Module: bcd_ascii_sender

Interface
REQ-001 Parameter BLANK_ZEROS, default 1, SHALL enable suppression of leading zeros in digit2/digit1.
REQ-002 Parameter SEND_CRLF, default 1, SHALL enable appending CR (0x0D) then LF (0x0A) after the last digit.
REQ-003 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to send the value on the digit inputs.
REQ-006 digit2 / digit1 / digit0  input  4 each  BCD hundreds / tens / units; sampled only on an accepted start.
REQ-007 tx_data  output  8  ASCII character offered to the byte transmitter.
REQ-008 tx_valid  output  1  tx_data is valid.
REQ-009 tx_ready  input  1  the transmitter accepts tx_data.
REQ-010 busy  output  1  a send is in progress.
REQ-011 done  output  1  one-cycle pulse: the send has completed.

Function
REQ-012 The FSM SHALL have states IDLE, D2, D1, D0, CR, LF and FIN.
REQ-013 In IDLE, start=1 SHALL latch all three digits and move to the first character state in the same edge.
- With BLANK_ZEROS=0, the first state is D2.
- Otherwise it is D2 if digit2!=0, else D1 if digit1!=0, else D0.
REQ-014 start outside IDLE SHALL be ignored, and the latched digits SHALL NOT change.
REQ-015 In D2, D1, D0, CR and LF, tx_valid SHALL be 1; in IDLE and FIN it SHALL be 0.
REQ-016 Digit states SHALL drive tx_data = 0x30 + digit for digit values 0..9, and 0x3F ('?') for values 10..15.
REQ-017 CR and LF states SHALL drive 0x0D and 0x0A respectively.
REQ-018 A transfer occurs on an edge where tx_valid=1 and tx_ready=1.
- Only a transfer SHALL advance the state: D2->D1->D0.
- D0 SHALL go to CR when SEND_CRLF=1, else to FIN.
- CR SHALL go to LF, and LF SHALL go to FIN.
REQ-019 While tx_valid=1 and tx_ready=0, tx_data SHALL remain stable and tx_valid SHALL remain 1 (no retraction).
REQ-020 FIN SHALL last exactly one cycle, assert done=1, and return to IDLE.
REQ-021 busy SHALL be 1 in D2, D1, D0, CR and LF, and 0 in IDLE and FIN.
- start asserted during FIN SHALL be ignored.
- start SHALL be accepted on the first IDLE cycle after FIN.
REQ-022 tx_ready held at 1 SHALL give one character per cycle, with the first tx_valid in the cycle after start.
REQ-023 Leading-zero blanking SHALL be decided only from the latched digits; the units digit SHALL always be sent.
REQ-024 Blanking SHALL be applied to the digit values, so a non-BCD digit2 (10..15) is not blank and is sent as '?'.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, tx_valid=0, tx_data=0x00, busy=0, done=0 and latched digits=0, including mid-send.
REQ-026 After rst_n rises, no character SHALL be offered until a new start is accepted.

Structure
REQ-027 Shared package bcd_pkg SHALL hold:
- the FSM state type;
- ASCII constants ASCII_ZERO=0x30, ASCII_QMARK=0x3F, ASCII_CR=0x0D, ASCII_LF=0x0A.
REQ-028 The combinational digit-to-character mapping SHALL be one sub-module, bcd_to_ascii (4-bit in, 8-bit out), instantiated once, fed by the digit selected for the current state.
REQ-029 All outputs SHALL be registered, except tx_valid and busy, which SHALL be decoded from the state register only.

Verification
REQ-030 Latched 1,2,3; tx_ready=1; defaults -> tx_data sequence 0x31,0x32,0x33,0x0D,0x0A on 5 consecutive cycles, then one done pulse.
REQ-031 Latched 0,0,7, BLANK_ZEROS=1 -> 0x37,0x0D,0x0A. Latched 0,0,0 -> 0x30,0x0D,0x0A. Latched 0,5,0 -> 0x35,0x30,0x0D,0x0A.
REQ-032 Latched 4,5,6 with tx_ready low for 3 cycles on every character -> same 5 bytes; tx_data stable during stalls; done after the 20th cycle.
REQ-033 start pulsed again mid-send with digits 9,9,9 -> first value's bytes unchanged and no extra send; start in FIN ignored; start in the next IDLE cycle accepted.
REQ-034 Latched 0xA,0,1 with BLANK_ZEROS=0, SEND_CRLF=0 -> 0x3F,0x30,0x31, then done.
REQ-035 rst_n low after 2 transferred bytes -> tx_valid, busy and done are 0 asynchronously; nothing is sent until the next start.
